packet_streamer: RTL and testbench

Parametrised successor to the combinational packet-byte selector. It snapshots a flattened packet bus on a start pulse and streams the bytes out one at a time over a valid/ready handshake. An optional XOR checksum byte can be appended after the payload. It sits between the packet builders and the serial transmitter, so the transmitter no longer drives a selector index.

---
 rtl/packet_streamer.sv | 99 +++++++++
 tb/tb_packet_streamer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_streamer.sv
// Snapshots a flattened packet on start and streams its elements over valid/ready,
// optionally followed by an XOR checksum element.
module packet_streamer #(
  parameter int                DATA_W       = 8,
  parameter int                MAX_BYTES    = 29,
  parameter int                LEN_W        = $clog2(MAX_BYTES + 1),
  parameter int                APPEND_CKSUM = 1,
  parameter logic [DATA_W-1:0] CKSUM_INIT   = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [MAX_BYTES*DATA_W-1:0] packet_flat,
  input  logic [LEN_W-1:0]            length,
  input  logic                        start,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  typedef enum logic [1:0] {IDLE, SEND, CKSUM} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] snap [MAX_BYTES];
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx;
  logic [DATA_W-1:0] acc;
  logic              len_ok, start_ok, xfer, last_payload;

  assign len_ok       = (length != '0) && (length <= LEN_W'(MAX_BYTES));
  assign start_ok     = (state == IDLE) && start && len_ok;
  assign xfer         = out_valid && out_ready;
  assign last_payload = (idx == len_q - LEN_W'(1));
  assign busy         = (state != IDLE);

  // Outputs are decoded from state so reset clears them without waiting for a clock.
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = snap[idx];
        out_last  = last_payload && (APPEND_CKSUM == 0);
        if (xfer && last_payload) state_nxt = (APPEND_CKSUM != 0) ? CKSUM : IDLE;
      end
      CKSUM: begin
        out_valid = 1'b1;
        out_data  = acc;
        out_last  = 1'b1;
        if (xfer) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state and control registers use non-blocking assignments and an async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      idx   <= '0;
      acc   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= xfer && out_last;
      err  <= (state == IDLE) && start && !len_ok;
      if (start_ok) begin
        len_q <= length;
        idx   <= '0;
        acc   <= CKSUM_INIT;
      end else if ((state == SEND) && xfer) begin
        idx <= idx + LEN_W'(1);
        acc <= acc ^ out_data;
      end
    end
  end

  // NOTE: the snapshot buffer has no reset; it is always rewritten before it is read.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      for (int i = 0; i < MAX_BYTES; i++) snap[i] <= packet_flat[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_packet_streamer.sv
// Directed self-checking bench for packet_streamer (checksum and no-checksum builds).
module tb_packet_streamer;

  localparam int DW = 8;
  localparam int MB = 29;
  localparam int LW = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [MB*DW-1:0] packet_flat;
  logic [LW-1:0]  length;
  logic           start, out_ready;
  logic [DW-1:0]  out_data;
  logic           out_valid, out_last, busy, done, err;

  logic [MB*DW-1:0] packet_flat_b;
  logic [LW-1:0]  length_b;
  logic           start_b, out_ready_b;
  logic [DW-1:0]  out_data_b;
  logic           out_valid_b, out_last_b, busy_b, done_b, err_b;

  int tests  = 0;
  int failed = 0;
  logic [7:0] exp_mem [0:31];
  logic [6:0] pat = 7'b1101001;  // ready pattern 1,0,0,1,0,1,1 from bit 0 upward
  logic [7:0] ck;

  always #5 clk = ~clk;

  packet_streamer #(.DATA_W(DW), .MAX_BYTES(MB), .APPEND_CKSUM(1), .CKSUM_INIT(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .packet_flat(packet_flat), .length(length), .start(start),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  packet_streamer #(.DATA_W(DW), .MAX_BYTES(MB), .APPEND_CKSUM(0), .CKSUM_INIT(8'h00)) dut_b (
    .clk(clk), .rst_n(rst_n), .packet_flat(packet_flat_b), .length(length_b), .start(start_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_last(out_last_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_elem(input int i, input logic [7:0] v);
    packet_flat[i*DW +: DW] = v;
  endtask

  // Receive n elements (payload + checksum) against exp_mem; mode 1 applies the ready pattern.
  task automatic recv(input int n, input int mode, input string tag);
    int k = 0;
    int cyc = 0;
    int pi = 0;
    logic [7:0] held = '0;
    logic stalled = 1'b0;
    while (k < n && cyc < 400) begin
      out_ready = (mode != 0) ? pat[pi % 7] : 1'b1;
      pi++;
      if (stalled) check({tag, " hold"}, out_data, held);
      if (out_valid && out_ready) begin
        check({tag, " data"}, out_data, exp_mem[k]);
        check({tag, " last"}, out_last, (k == n - 1));
        check({tag, " busy"}, busy, 1'b1);
        k++;
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1;
        held    = out_data;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    if (k < n) check({tag, " timeout"}, k, n);
  endtask

  task automatic expect_done(input string tag);
    check({tag, " done"}, done, 1'b1);
    check({tag, " valid_off"}, out_valid, 1'b0);
    check({tag, " busy_off"}, busy, 1'b0);
  endtask

  task automatic load_basic();
    packet_flat = '0;
    set_elem(0, 8'h12); set_elem(1, 8'h34); set_elem(2, 8'h56);
    length = 5'd3;
    exp_mem[0] = 8'h12; exp_mem[1] = 8'h34; exp_mem[2] = 8'h56; exp_mem[3] = 8'h70;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; packet_flat = '0; length = '0; start = 1'b0; out_ready = 1'b0;
    packet_flat_b = '0; length_b = '0; start_b = 1'b0; out_ready_b = 1'b0;
    tick(); tick();

    // Reset state
    check("rst out_data", out_data, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_last", out_last, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    rst_n = 1'b1;
    tick();

    // Basic packet, ready held high
    load_basic();
    start = 1'b1; tick(); start = 1'b0;
    check("basic first valid", out_valid, 1);
    recv(4, 0, "basic");
    expect_done("basic");
    tick();
    check("basic done one cycle", done, 0);

    // Backpressure
    load_basic();
    start = 1'b1; tick(); start = 1'b0;
    recv(4, 1, "bp");
    expect_done("bp");
    tick();

    // Maximum length
    packet_flat = '0;
    ck = 8'h00;
    for (int i = 0; i < MB; i++) begin
      set_elem(i, 8'(i * 7 + 3));
      exp_mem[i] = 8'(i * 7 + 3);
      ck = ck ^ 8'(i * 7 + 3);
    end
    exp_mem[MB] = ck;
    length = 5'd29;
    start = 1'b1; tick(); start = 1'b0;
    recv(MB + 1, 0, "len29");
    expect_done("len29");
    tick();

    // Length 1
    packet_flat = '0; set_elem(0, 8'hA5); length = 5'd1;
    exp_mem[0] = 8'hA5; exp_mem[1] = 8'hA5;
    start = 1'b1; tick(); start = 1'b0;
    recv(2, 0, "len1");
    expect_done("len1");
    tick();

    // No-checksum build, length 1
    packet_flat_b = '0; packet_flat_b[7:0] = 8'h3C; length_b = 5'd1;
    start_b = 1'b1; tick(); start_b = 1'b0;
    check("nock valid", out_valid_b, 1);
    check("nock data", out_data_b, 8'h3C);
    check("nock last", out_last_b, 1);
    out_ready_b = 1'b1; tick(); out_ready_b = 1'b0;
    check("nock done", done_b, 1);
    check("nock valid_off", out_valid_b, 0);
    check("nock busy_off", busy_b, 0);
    tick();

    // Illegal lengths
    length = 5'd0; start = 1'b1; tick(); start = 1'b0;
    check("len0 err", err, 1);
    check("len0 valid", out_valid, 0);
    tick();
    check("len0 err pulse", err, 0);
    check("len0 still idle", out_valid, 0);
    length = 5'd30; start = 1'b1; tick(); start = 1'b0;
    check("len30 err", err, 1);
    check("len30 valid", out_valid, 0);
    tick();

    // Start while busy is ignored
    load_basic();
    start = 1'b1; tick(); start = 1'b0;
    packet_flat = '0; set_elem(0, 8'hEE); set_elem(1, 8'hDD); length = 5'd2;
    start = 1'b1; out_ready = 1'b0; tick(); start = 1'b0;
    check("busy start err", err, 0);
    recv(4, 0, "ignore");
    expect_done("ignore");
    tick();
    check("ignore no restart", out_valid, 0);

    // Snapshot isolation, then a start coincident with done
    load_basic();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    packet_flat = {(MB*DW){1'b1}}; length = 5'd7;
    recv(4, 0, "snap");
    expect_done("snap");
    packet_flat = '0; set_elem(0, 8'h81); set_elem(1, 8'h42); length = 5'd2;
    exp_mem[0] = 8'h81; exp_mem[1] = 8'h42; exp_mem[2] = 8'hC3;
    start = 1'b1; tick(); start = 1'b0;
    check("b2b valid", out_valid, 1);
    check("b2b data0", out_data, 8'h81);
    recv(3, 0, "b2b");
    expect_done("b2b");
    tick();

    // Reset in the middle of a packet
    packet_flat = '0;
    for (int i = 0; i < 5; i++) set_elem(i, 8'(8'h10 + i));
    length = 5'd5;
    start = 1'b1; tick(); start = 1'b0;
    out_ready = 1'b1; tick();
    check("mid elem1", out_data, 8'h11);
    tick(); out_ready = 1'b0;
    check("mid elem2", out_data, 8'h12);
    #1 rst_n = 1'b0;
    #1;
    check("mid rst valid", out_valid, 0);
    check("mid rst data", out_data, 0);
    check("mid rst last", out_last, 0);
    check("mid rst busy", busy, 0);
    check("mid rst done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post rst done", done, 0);
    check("post rst idle", out_valid, 0);
    packet_flat = '0; set_elem(0, 8'h0F); set_elem(1, 8'hF1); length = 5'd2;
    exp_mem[0] = 8'h0F; exp_mem[1] = 8'hF1; exp_mem[2] = 8'hFE;
    start = 1'b1; tick(); start = 1'b0;
    recv(3, 0, "post rst");
    expect_done("post rst");
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
